// File: rtl/lamp_sequence_monitor.sv
// Traffic-lamp sequence monitor: locks onto red->green->yellow->red, flags
// illegal codes, out-of-order lamps and stuck lamps, and counts completed cycles.
module lamp_sequence_monitor #(
  parameter int MAX_DWELL = 1,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       light,
  output logic             locked,
  output logic [2:0]       phase,
  output logic             err,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] cycle_count
);

  localparam int DW = $clog2(MAX_DWELL + 2);
  localparam logic [DW-1:0] MAX_D = DW'(MAX_DWELL);

  localparam logic [2:0] LAMP_RED    = 3'b001;
  localparam logic [2:0] LAMP_GREEN  = 3'b010;
  localparam logic [2:0] LAMP_YELLOW = 3'b100;

  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_ORDER   = 2'b10;
  localparam logic [1:0] ERR_STUCK   = 2'b11;

  typedef enum logic [1:0] {HUNT, RED, GREEN, YELLOW} state_t;

  state_t           state_q, state_d;
  logic [DW-1:0]    dwell_q, dwell_d;
  logic             locked_q, locked_d;
  logic [2:0]       phase_q, phase_d;
  logic             err_q, err_d;
  logic [1:0]       err_code_q, err_code_d;
  logic [CNT_W-1:0] cycle_count_q, cycle_count_d;

  logic [2:0] cur_code;
  logic [2:0] succ_code;
  state_t     succ_state;
  logic       one_hot;
  logic       fault;
  logic [1:0] fault_code;

  always_comb begin
    cur_code   = 3'b000;
    succ_code  = LAMP_RED;
    succ_state = RED;
    unique case (state_q)
      RED:     begin cur_code = LAMP_RED;    succ_code = LAMP_GREEN;  succ_state = GREEN;  end
      GREEN:   begin cur_code = LAMP_GREEN;  succ_code = LAMP_YELLOW; succ_state = YELLOW; end
      YELLOW:  begin cur_code = LAMP_YELLOW; succ_code = LAMP_RED;    succ_state = RED;    end
      default: begin cur_code = 3'b000;      succ_code = LAMP_RED;    succ_state = RED;    end
    endcase
  end

  assign one_hot = (light == LAMP_RED) || (light == LAMP_GREEN) || (light == LAMP_YELLOW);

  always_comb begin
    state_d       = state_q;
    dwell_d       = dwell_q;
    locked_d      = locked_q;
    phase_d       = phase_q;
    err_d         = 1'b0;
    err_code_d    = err_code_q;
    cycle_count_d = cycle_count_q;
    fault         = 1'b0;
    fault_code    = 2'b00;

    if (state_q == HUNT) begin
      // Only red can start tracking; everything else is ignored silently.
      if (light == LAMP_RED) begin
        state_d  = RED;
        dwell_d  = DW'(1);
        locked_d = 1'b1;
        phase_d  = LAMP_RED;
      end
    end else if (!one_hot) begin
      fault      = 1'b1;
      fault_code = ERR_ILLEGAL;
    end else if (light == succ_code) begin
      state_d  = succ_state;
      dwell_d  = DW'(1);
      phase_d  = succ_code;
      if (state_q == YELLOW && cycle_count_q != {CNT_W{1'b1}})
        cycle_count_d = cycle_count_q + CNT_W'(1);
    end else if (light == cur_code) begin
      if (dwell_q >= MAX_D) begin
        fault      = 1'b1;
        fault_code = ERR_STUCK;
      end else begin
        dwell_d = dwell_q + DW'(1);
      end
    end else begin
      fault      = 1'b1;
      fault_code = ERR_ORDER;
    end

    // Any violation drops back to HUNT; the offending sample never relocks.
    if (fault) begin
      state_d    = HUNT;
      dwell_d    = '0;
      locked_d   = 1'b0;
      phase_d    = 3'b000;
      err_d      = 1'b1;
      err_code_d = fault_code;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= HUNT;
      dwell_q       <= '0;
      locked_q      <= 1'b0;
      phase_q       <= 3'b000;
      err_q         <= 1'b0;
      err_code_q    <= 2'b00;
      cycle_count_q <= '0;
    end else begin
      state_q       <= state_d;
      dwell_q       <= dwell_d;
      locked_q      <= locked_d;
      phase_q       <= phase_d;
      err_q         <= err_d;
      err_code_q    <= err_code_d;
      cycle_count_q <= cycle_count_d;
    end
  end

  assign locked      = locked_q;
  assign phase       = phase_q;
  assign err         = err_q;
  assign err_code    = err_code_q;
  assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_lamp_sequence_monitor.sv
// Directed bench for lamp_sequence_monitor: one instance at MAX_DWELL=1, one at MAX_DWELL=4.
module tb_lamp_sequence_monitor;

  localparam logic [2:0] R = 3'b001;
  localparam logic [2:0] G = 3'b010;
  localparam logic [2:0] Y = 3'b100;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] light1 = 3'b000;
  logic [2:0] light4 = 3'b000;

  logic       locked1, err1, locked4, err4;
  logic [2:0] phase1, phase4;
  logic [1:0] errCode1, errCode4;
  logic [7:0] count1, count4;

  int assertCount = 0;
  int failCount   = 0;
  int expCount;

  always #5 clk = ~clk;

  lamp_sequence_monitor #(.MAX_DWELL(1), .CNT_W(8)) dut1 (
    .clk(clk), .rst(rst), .light(light1), .locked(locked1), .phase(phase1),
    .err(err1), .err_code(errCode1), .cycle_count(count1)
  );

  lamp_sequence_monitor #(.MAX_DWELL(4), .CNT_W(8)) dut4 (
    .clk(clk), .rst(rst), .light(light4), .locked(locked4), .phase(phase4),
    .err(err4), .err_code(errCode4), .cycle_count(count4)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Drive one sample on the falling edge, then look at outputs just after the rising edge.
  task automatic applyStimulus(input logic [2:0] l1, input logic [2:0] l4, input logic r);
    @(negedge clk);
    light1 = l1;
    light4 = l4;
    rst    = r;
    @(posedge clk);
    #1;
  endtask

  task automatic checkDut1(input string tag, input logic lk, input logic [2:0] ph,
                           input logic e, input logic [1:0] ec, input logic [7:0] cnt);
    checkOutput({tag, ".locked"}, 32'(locked1), 32'(lk));
    checkOutput({tag, ".phase"}, 32'(phase1), 32'(ph));
    checkOutput({tag, ".err"}, 32'(err1), 32'(e));
    checkOutput({tag, ".err_code"}, 32'(errCode1), 32'(ec));
    checkOutput({tag, ".count"}, 32'(count1), 32'(cnt));
  endtask

  initial begin
    // Reset, even with a red lamp present, leaves everything zero.
    applyStimulus(R, R, 1'b1);
    checkDut1("reset", 0, 3'b000, 0, 2'b00, 8'd0);
    checkOutput("reset.locked4", 32'(locked4), 0);

    // Clean stream R,G,Y,R,G,Y,R.
    applyStimulus(R, 3'b000, 1'b0); checkDut1("s1R", 1, R, 0, 2'b00, 8'd0);
    applyStimulus(G, 3'b000, 1'b0); checkDut1("s2G", 1, G, 0, 2'b00, 8'd0);
    applyStimulus(Y, 3'b000, 1'b0); checkDut1("s3Y", 1, Y, 0, 2'b00, 8'd0);
    applyStimulus(R, 3'b000, 1'b0); checkDut1("s4R", 1, R, 0, 2'b00, 8'd1);
    applyStimulus(G, 3'b000, 1'b0); checkDut1("s5G", 1, G, 0, 2'b00, 8'd1);
    applyStimulus(Y, 3'b000, 1'b0); checkDut1("s6Y", 1, Y, 0, 2'b00, 8'd1);
    applyStimulus(R, 3'b000, 1'b0); checkDut1("s7R", 1, R, 0, 2'b00, 8'd2);

    // Illegal code while in GREEN, then relock on red.
    applyStimulus(G, 3'b000, 1'b0);     checkDut1("ill.G", 1, G, 0, 2'b00, 8'd2);
    applyStimulus(3'b011, 3'b000, 1'b0); checkDut1("ill.err", 0, 3'b000, 1, 2'b01, 8'd2);
    applyStimulus(R, 3'b000, 1'b0);     checkDut1("ill.relock", 1, R, 0, 2'b01, 8'd2);

    // Order error: yellow while in RED; the same yellow does not lock.
    applyStimulus(Y, 3'b000, 1'b0); checkDut1("ord.err", 0, 3'b000, 1, 2'b10, 8'd2);
    applyStimulus(Y, 3'b000, 1'b0); checkDut1("ord.hunt", 0, 3'b000, 0, 2'b10, 8'd2);
    applyStimulus(3'b111, 3'b000, 1'b0); checkDut1("hunt.illegal", 0, 3'b000, 0, 2'b10, 8'd2);
    applyStimulus(R, 3'b000, 1'b0); checkDut1("ord.relock", 1, R, 0, 2'b10, 8'd2);

    // Stuck with MAX_DWELL=1: second red in a row; that red does not relock.
    applyStimulus(R, 3'b000, 1'b0); checkDut1("stuck1.err", 0, 3'b000, 1, 2'b11, 8'd2);

    // MAX_DWELL=4: four reds are fine, the fifth is stuck.
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(3'b000, R, 1'b0);
      checkOutput($sformatf("dw4.r%0d.locked", i), 32'(locked4), 1);
      checkOutput($sformatf("dw4.r%0d.err", i), 32'(err4), 0);
    end
    applyStimulus(3'b000, R, 1'b0);
    checkOutput("dw4.r5.err", 32'(err4), 1);
    checkOutput("dw4.r5.code", 32'(errCode4), 32'(2'b11));
    checkOutput("dw4.r5.locked", 32'(locked4), 0);
    applyStimulus(3'b000, G, 1'b0);
    checkOutput("dw4.pulse", 32'(err4), 0);
    checkOutput("dw4.count", 32'(count4), 0);

    // Saturation: relock (count 2), then 300 clean cycles.
    applyStimulus(R, 3'b000, 1'b0); checkDut1("sat.lock", 1, R, 0, 2'b11, 8'd2);
    for (int i = 1; i <= 300; i++) begin
      applyStimulus(G, 3'b000, 1'b0);
      applyStimulus(Y, 3'b000, 1'b0);
      applyStimulus(R, 3'b000, 1'b0);
      expCount = (2 + i > 255) ? 255 : 2 + i;
      checkOutput($sformatf("sat.count%0d", i), 32'(count1), 32'(expCount));
    end
    checkDut1("sat.end", 1, R, 0, 2'b11, 8'd255);

    // Mid-sequence reset with err_code=10 and cycle_count=7.
    applyStimulus(R, 3'b000, 1'b1); checkDut1("rst2", 0, 3'b000, 0, 2'b00, 8'd0);
    applyStimulus(R, 3'b000, 1'b0);
    for (int i = 0; i < 7; i++) begin
      applyStimulus(G, 3'b000, 1'b0);
      applyStimulus(Y, 3'b000, 1'b0);
      applyStimulus(R, 3'b000, 1'b0);
    end
    checkDut1("pre.count7", 1, R, 0, 2'b00, 8'd7);
    applyStimulus(Y, 3'b000, 1'b0); checkDut1("pre.order", 0, 3'b000, 1, 2'b10, 8'd7);
    applyStimulus(R, 3'b000, 1'b0); checkDut1("pre.relock", 1, R, 0, 2'b10, 8'd7);
    applyStimulus(G, 3'b000, 1'b0); checkDut1("pre.G", 1, G, 0, 2'b10, 8'd7);
    // Reset wins over a simultaneous illegal sample.
    applyStimulus(3'b111, 3'b000, 1'b1); checkDut1("rst3", 0, 3'b000, 0, 2'b00, 8'd0);
    applyStimulus(G, 3'b000, 1'b0); checkDut1("post.hunt", 0, 3'b000, 0, 2'b00, 8'd0);
    applyStimulus(Y, 3'b000, 1'b0); checkDut1("post.hunt2", 0, 3'b000, 0, 2'b00, 8'd0);
    applyStimulus(R, 3'b000, 1'b0); checkDut1("post.lock", 1, R, 0, 2'b00, 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
